// File: rtl/bk_serial_addsub_if.sv
// Request/result bundle for bk_serial_addsub. zero/ovf exist only when
// BK_SERIAL_FLAGS_EN is defined.
interface bk_serial_addsub_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    // Handshake: a transfer happens on a rising clk edge where valid && ready;
    // valid may not depend on ready, payload is held while valid && !ready.
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
`ifdef BK_SERIAL_FLAGS_EN
    logic         zero;
    logic         ovf;
`endif

    modport master (
        output in_valid, op, x1, x2, out_ready,
        input  in_ready, out_valid, s, cout
`ifdef BK_SERIAL_FLAGS_EN
        , input zero, ovf
`endif
    );

    modport slave (
        input  in_valid, op, x1, x2, out_ready,
        output in_ready, out_valid, s, cout
`ifdef BK_SERIAL_FLAGS_EN
        , output zero, ovf
`endif
    );
endinterface

// File: rtl/bk_serial_addsub.sv
// Nibble-serial unsigned add/subtract: one 4-bit Brent-Kung slice per cycle.
// Define BK_SERIAL_FLAGS_EN to add the registered zero and ovf result flags.
module bk_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bk_serial_addsub_if.slave     bus,
    output logic [1:0]            dbg_state
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   s_q;
    logic           cout_q;
`ifdef BK_SERIAL_FLAGS_EN
    logic           zero_q;
    logic           ovf_q;
`endif

    logic [3:0]     slice_a;
    logic [3:0]     slice_b;
    logic [3:0]     slice_sum;
    logic           slice_cout;
    logic [W-1:0]   s_next;

    // Returns {carry_out, sum[3:0]} using a two-level Brent-Kung prefix tree.
    function automatic logic [4:0] bk_slice(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic       cin);
        logic [3:0] p;
        logic [3:0] g;
        logic       g10, p10, g32, p32, g30, p30, g20, p20;
        logic [4:0] c;
        p   = a ^ b;
        g   = a & b;
        g10 = g[1] | (p[1] & g[0]);
        p10 = p[1] & p[0];
        g32 = g[3] | (p[3] & g[2]);
        p32 = p[3] & p[2];
        g30 = g32 | (p32 & g10);
        p30 = p32 & p10;
        g20 = g[2] | (p[2] & g10);
        p20 = p[2] & p10;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g10 | (p10 & cin);
        c[3] = g20 | (p20 & cin);
        c[4] = g30 | (p30 & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    always_comb begin
        slice_a = a_q[{idx, 2'b00} +: 4];
        slice_b = b_q[{idx, 2'b00} +: 4];
        {slice_cout, slice_sum} = bk_slice(slice_a, slice_b, carry);
        s_next = s_q;
        s_next[{idx, 2'b00} +: 4] = slice_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
`ifdef BK_SERIAL_FLAGS_EN
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract is x1 + ~x2 + 1: invert once here, seed carry with op.
                        a_q    <= bus.x1;
                        b_q    <= bus.op ? ~bus.x2 : bus.x2;
                        carry  <= bus.op;
                        idx    <= '0;
                        s_q    <= '0;
                        cout_q <= 1'b0;
`ifdef BK_SERIAL_FLAGS_EN
                        zero_q <= 1'b0;
                        ovf_q  <= 1'b0;
`endif
                        state  <= RUN;
                    end
                end
                RUN: begin
                    s_q   <= s_next;
                    carry <= slice_cout;
                    idx   <= idx + IW'(1);
                    if (idx == IW'(NIBBLES - 1)) begin
                        idx    <= '0;
                        cout_q <= slice_cout;
`ifdef BK_SERIAL_FLAGS_EN
                        zero_q <= (s_next == '0);
                        // Carry into the MSB is recovered as sum ^ a ^ b at bit 3.
                        ovf_q  <= (slice_sum[3] ^ slice_a[3] ^ slice_b[3]) ^ slice_cout;
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
`ifdef BK_SERIAL_FLAGS_EN
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
`endif
    assign dbg_state     = state;
endmodule

// File: tb/tb_bk_serial_addsub.sv
// Scoreboard bench for bk_serial_addsub: directed corner cases plus random
// add/subtract traffic with random consumer back-pressure.
module tb_bk_serial_addsub;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  bk_serial_addsub_if #(.NIBBLES(NIBBLES)) bus ();

  bk_serial_addsub #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  exp_t        exp_q[$];
  int unsigned acc_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic flag_error(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
    exp_t e;
    if (!o) begin
      {e.cout, e.s} = {1'b0, a} + {1'b0, b};
      e.ovf = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
    end else begin
      e.s    = a - b;
      e.cout = (a >= b);
      e.ovf  = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
    end
    e.zero = (e.s == '0);
    return e;
  endfunction

  // ---------------- consumer ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'($urandom_range(0, 1));
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  logic         prev_valid = 1'b0;
  logic         prev_hs    = 1'b0;
  logic [W-1:0] prev_s     = '0;
  logic         prev_cout  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
      if (prev_hs) begin
        check("in_ready_after_handshake", W'(bus.in_ready), W'(1));
        check("out_valid_after_handshake", W'(bus.out_valid), W'(0));
      end
      if (bus.out_valid) begin
        check("in_ready_while_done", W'(bus.in_ready), W'(0));
        if (!prev_valid) begin
          if (acc_q.size() == 0) flag_error("out_valid_without_request");
          else check("latency", W'(cyc - acc_q.pop_front()), W'(NIBBLES));
        end else if (!prev_hs) begin
          check("hold_s", bus.s, prev_s);
          check("hold_cout", W'(bus.cout), W'(prev_cout));
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) flag_error("result_without_expectation");
          else begin
            exp_t e;
            e = exp_q.pop_front();
            check("s", bus.s, e.s);
            check("cout", W'(bus.cout), W'(e.cout));
`ifdef BK_SERIAL_FLAGS_EN
            check("zero", W'(bus.zero), W'(e.zero));
            check("ovf", W'(bus.ovf), W'(e.ovf));
`endif
          end
        end
      end
      prev_valid = bus.out_valid;
      prev_hs    = bus.out_valid && bus.out_ready;
      prev_s     = bus.s;
      prev_cout  = bus.cout;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                       input bit noise);
    bit accepted = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.x1 = a;
    bus.x2 = b;
    bus.op = o;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) accepted = 1'b1;
    end
    if (!accepted) begin
      flag_error("request_not_accepted");
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(a, b, o));
    @(posedge clk);
    #1;
    // Scramble operands after capture; optionally keep pushing ignored requests.
    bus.in_valid = noise;
    bus.x1 = W'($urandom);
    bus.x2 = W'($urandom);
    bus.op = 1'($urandom_range(0, 1));
    if (noise) begin
      repeat (2) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_out_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    if (!seen) flag_error("out_valid_timeout");
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.op = 1'b0;
    bus.x1 = '0;
    bus.x2 = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", W'(bus.in_ready), W'(1));
    check("reset_out_valid", W'(bus.out_valid), W'(0));
    check("reset_s", bus.s, '0);
    check("reset_cout", W'(bus.cout), W'(0));
    check("reset_state", W'(dbg_state), W'(0));
`ifdef BK_SERIAL_FLAGS_EN
    check("reset_zero", W'(bus.zero), W'(0));
    check("reset_ovf", W'(bus.ovf), W'(0));
`endif
    rst = 1'b0;

    rdy_mode = 1;
    issue(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    drain();
    issue(16'h0005, 16'h0007, 1'b1, 1'b0);
    drain();
    issue(16'h8000, 16'h0001, 1'b1, 1'b0);
    drain();
    issue(16'h0000, 16'h0000, 1'b1, 1'b0);
    drain();
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    drain();

    // Consumer stalls ten cycles on a wrapping add.
    rdy_mode = 2;
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_out_valid();
    repeat (10) @(posedge clk);
    rdy_mode = 1;
    drain();

    // Reset during the second RUN cycle discards the result.
    issue(W'($urandom), W'($urandom), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    check("midrun_reset_in_ready", W'(bus.in_ready), W'(1));
    check("midrun_reset_out_valid", W'(bus.out_valid), W'(0));
    check("midrun_reset_s", bus.s, '0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain();

    // New requests presented while busy must be ignored.
    issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
    drain();

    rdy_mode = 0;
    repeat (40) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
    rdy_mode = 1;
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
